// File: rtl/rv32i_pkg.sv
// rv32i -- shared types and constants for the CSR access path.
//
// Contents:
//   reg_we_e     write-enable encoding for CSR storage
//   csr_op_e     CSR instruction funct3 encodings
//   csr_state_e  state encoding of the CSR access controller
//   CSR_MEPC / CSR_MCAUSE  machine trap CSR addresses
//   CSR_RO_SPACE           addr[11:10] pattern of the read-only CSR space
package rv32i;

    typedef enum logic {
        REG_WE_DISABLE = 1'b0,
        REG_WE         = 1'b1
    } reg_we_e;

    // funct3 codes 3'b000 and 3'b100 are not CSR operations; they are
    // handled as raw bit patterns by the ALU and flagged illegal there.
    typedef enum logic [2:0] {
        CSR_OP_RW  = 3'b001,
        CSR_OP_RS  = 3'b010,
        CSR_OP_RC  = 3'b011,
        CSR_OP_RWI = 3'b101,
        CSR_OP_RSI = 3'b110,
        CSR_OP_RCI = 3'b111
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_TRAP_EPC,
        ST_TRAP_CAUSE
    } csr_state_e;

    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [1:0]  CSR_RO_SPACE = 2'b11;

endpackage

// File: rtl/csr_alu.sv
// csr_alu -- combinational new-value / write-intent / legality computation
// for one CSR instruction.
//
// Ports:
//   op_i        funct3 of the instruction (raw 3 bits, may be illegal)
//   addr_i      CSR address
//   src_i       rs1 value or zero-extended zimm
//   src_zero_i  rs1 index / zimm is zero
//   rdata_i     current CSR value
//   wdata_o     value to write back
//   write_o     instruction intends to write the CSR
//   illegal_o   instruction raises an illegal-instruction exception
module csr_alu
    import rv32i::*;
#(
    parameter bit RO_CHECK = 1'b1
) (
    input  logic [2:0]  op_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] src_i,
    input  logic        src_zero_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic        write_o,
    output logic        illegal_o
);

    logic writeIntent;
    logic opIllegal;
    logic roViolation;

    // Decode the operation: set/clear forms only write when their source
    // is non-zero, which is what lets "csrrs rd, csr, x0" act as a pure read.
    always_comb begin
        wdata_o     = rdata_i;
        writeIntent = 1'b0;
        opIllegal   = 1'b0;
        case (op_i)
            CSR_OP_RW, CSR_OP_RWI: begin
                wdata_o     = src_i;
                writeIntent = 1'b1;
            end
            CSR_OP_RS, CSR_OP_RSI: begin
                wdata_o     = rdata_i | src_i;
                writeIntent = !src_zero_i;
            end
            CSR_OP_RC, CSR_OP_RCI: begin
                wdata_o     = rdata_i & ~src_i;
                writeIntent = !src_zero_i;
            end
            default: begin
                opIllegal = 1'b1;
            end
        endcase
    end

    // A write aimed at the read-only quadrant is illegal, but a read of it is fine.
    assign roViolation = RO_CHECK && writeIntent && (addr_i[11:10] == CSR_RO_SPACE);
    assign illegal_o   = opIllegal || roViolation;
    assign write_o     = writeIntent;

endmodule

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl -- sequences CSR instructions and trap entry onto the
// single port of the CSR storage block. It is the only writer of that storage.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         CSR instruction handshake
//   req_op/req_addr/req_src     funct3, CSR address, rs1 value or zimm
//   req_src_zero                rs1 index / zimm is zero
//   rsp_valid/rsp_rdata         one-cycle completion pulse with old CSR value
//   rsp_illegal                 illegal-instruction flag (with rsp_valid)
//   trap_valid/trap_pc/trap_cause  trap entry request, held until trap_ack
//   trap_ack                    pulse once mepc and mcause are written
//   csr_we/csr_addr/csr_wdata   storage write port and read address
//   csr_rdata                   combinational storage read of csr_addr
module csr_access_ctrl
    import rv32i::*;
#(
    parameter bit RO_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_src,
    input  logic        req_src_zero,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_illegal,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    output logic        trap_ack,
    output reg_we_e     csr_we,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata
);

    csr_state_e  state_q;
    logic [2:0]  op_q;
    logic [31:0] src_q;
    logic        srcZero_q;
    logic [31:0] rdata_q;
    logic        rspValid_q;
    logic        rspIllegal_q;
    logic        trapAck_q;
    reg_we_e     csrWe_q;
    logic [11:0] csrAddr_q;
    logic [31:0] csrWdata_q;

    logic [31:0] aluWdata;
    logic        aluWrite;
    logic        aluIllegal;

    // The ALU works on the latched instruction and the live storage read,
    // which is valid during READ because csr_addr already holds the latched address.
    csr_alu #(
        .RO_CHECK   (RO_CHECK)
    ) u_csr_alu (
        .op_i       (op_q),
        .addr_i     (csrAddr_q),
        .src_i      (src_q),
        .src_zero_i (srcZero_q),
        .rdata_i    (csr_rdata),
        .wdata_o    (aluWdata),
        .write_o    (aluWrite),
        .illegal_o  (aluIllegal)
    );

    // A pending trap blocks new requests so it is always served first.
    assign req_ready = (state_q == ST_IDLE) && !trap_valid;

    // Controller FSM. All storage-port and response outputs are registered
    // here, so each is set up one state ahead of the cycle in which it is seen:
    // IDLE arms the mepc write, READ arms the write-back and response,
    // TRAP_EPC arms the mcause write together with trap_ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= 3'b000;
            src_q        <= 32'h0;
            srcZero_q    <= 1'b0;
            rdata_q      <= 32'h0;
            rspValid_q   <= 1'b0;
            rspIllegal_q <= 1'b0;
            trapAck_q    <= 1'b0;
            csrWe_q      <= REG_WE_DISABLE;
            csrAddr_q    <= 12'h0;
            csrWdata_q   <= 32'h0;
        end else begin
            rspValid_q   <= 1'b0;
            rspIllegal_q <= 1'b0;
            trapAck_q    <= 1'b0;
            csrWe_q      <= REG_WE_DISABLE;
            case (state_q)
                ST_IDLE: begin
                    if (trap_valid) begin
                        csrAddr_q  <= CSR_MEPC;
                        csrWdata_q <= {trap_pc[31:2], 2'b00};
                        csrWe_q    <= REG_WE;
                        state_q    <= ST_TRAP_EPC;
                    end else if (req_valid) begin
                        op_q      <= req_op;
                        csrAddr_q <= req_addr;
                        src_q     <= req_src;
                        srcZero_q <= req_src_zero;
                        state_q   <= ST_READ;
                    end
                end
                ST_READ: begin
                    rdata_q      <= aluIllegal ? 32'h0 : csr_rdata;
                    csrWdata_q   <= aluWdata;
                    csrWe_q      <= (aluWrite && !aluIllegal) ? REG_WE : REG_WE_DISABLE;
                    rspValid_q   <= 1'b1;
                    rspIllegal_q <= aluIllegal;
                    state_q      <= ST_WRITE;
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                end
                ST_TRAP_EPC: begin
                    csrAddr_q  <= CSR_MCAUSE;
                    csrWdata_q <= trap_cause;
                    csrWe_q    <= REG_WE;
                    trapAck_q  <= 1'b1;
                    state_q    <= ST_TRAP_CAUSE;
                end
                ST_TRAP_CAUSE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rspValid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_illegal = rspIllegal_q;
    assign trap_ack    = trapAck_q;
    assign csr_we      = csrWe_q;
    assign csr_addr    = csrAddr_q;
    assign csr_wdata   = csrWdata_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl -- scoreboard bench for csr_access_ctrl. The bench owns a
// behavioural CSR storage array that the DUT writes and reads.
module tb_csr_access_ctrl;
    import rv32i::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b000;
    logic [11:0] req_addr = 12'h0;
    logic [31:0] req_src = 32'h0;
    logic        req_src_zero = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_pc = 32'h0;
    logic [31:0] trap_cause = 32'h0;
    logic        trap_ack;
    reg_we_e     csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        int          cycle;
    } expRsp_t;

    expRsp_t     expQ[$];
    int          compareCount = 0;
    int          mismatchCount = 0;
    int          cycleNum = 0;
    int          rspCount = 0;
    int          writeCount = 0;
    int          pushCount = 0;

    logic [31:0] mem [0:4095];
    logic        pokeEn = 1'b0;
    logic [11:0] pokeAddr = 12'h0;
    logic [31:0] pokeData = 32'h0;

    csr_access_ctrl #(
        .RO_CHECK     (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_src      (req_src),
        .req_src_zero (req_src_zero),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_illegal  (rsp_illegal),
        .trap_valid   (trap_valid),
        .trap_pc      (trap_pc),
        .trap_cause   (trap_cause),
        .trap_ack     (trap_ack),
        .csr_we       (csr_we),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata)
    );

    always #5 clk = ~clk;

    // Storage model: the DUT write port has priority over bench preloads,
    // which are only issued while the DUT is idle anyway.
    always @(posedge clk) begin
        cycleNum <= cycleNum + 1;
        if (csr_we == REG_WE) begin
            mem[csr_addr] <= csr_wdata;
            writeCount    <= writeCount + 1;
        end else if (pokeEn) begin
            mem[pokeAddr] <= pokeData;
        end
        if (rsp_valid) begin
            rspCount <= rspCount + 1;
        end
    end

    assign csr_rdata = mem[csr_addr];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic pokeStorage(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk);
        pokeAddr = addr;
        pokeData = data;
        pokeEn   = 1'b1;
        @(negedge clk);
        pokeEn   = 1'b0;
    endtask

    // Drives one request from just after a negedge, waits (bounded) for
    // acceptance and pushes the expected response with its due cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                                 input logic srcZero, input logic [31:0] expRdata, input logic expIllegal,
                                 output int acceptCycle);
        bit accepted = 1'b0;
        acceptCycle  = -1;
        req_op       = op;
        req_addr     = addr;
        req_src      = src;
        req_src_zero = srcZero;
        req_valid    = 1'b1;
        #1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (req_ready) begin
                accepted    = 1'b1;
                acceptCycle = cycleNum;
                expQ.push_back('{expRdata, expIllegal, cycleNum + 2});
                pushCount++;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!accepted) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end
    endtask

    task automatic collectResponse(input string tag);
        bit      got = 1'b0;
        expRsp_t e;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        if (!got) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
            if (expQ.size() > 0) void'(expQ.pop_front());
        end else if (expQ.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "_rdata"}, rsp_rdata, e.rdata);
            checkOutput({tag, "_illegal"}, 32'(rsp_illegal), 32'(e.illegal));
            checkOutput({tag, "_cycle"}, 32'(cycleNum), 32'(e.cycle));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int t0;
        int wc;
        int rc;
        bit ackSeen;
        bit readySeen;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_rspValid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rspIllegal", 32'(rsp_illegal), 32'd0);
        checkOutput("rst_rspRdata", rsp_rdata, 32'd0);
        checkOutput("rst_trapAck", 32'(trap_ack), 32'd0);
        checkOutput("rst_csrWe", 32'(csr_we), 32'(REG_WE_DISABLE));
        checkOutput("rst_csrAddr", 32'(csr_addr), 32'd0);
        checkOutput("rst_csrWdata", csr_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 checkOutput("rst_reqReady", 32'(req_ready), 32'd1);

        // CSRRW: old value returned, new value stored
        pokeStorage(12'h300, 32'h0000_0008);
        applyStimulus(CSR_OP_RW, 12'h300, 32'h0000_1888, 1'b0, 32'h8, 1'b0, acc);
        collectResponse("csrrw");
        @(negedge clk);
        checkOutput("csrrw_store", mem[12'h300], 32'h0000_1888);

        // CSRRS with zero source is a pure read
        pokeStorage(12'h300, 32'h0000_000A);
        wc = writeCount;
        applyStimulus(CSR_OP_RS, 12'h300, 32'h0, 1'b1, 32'hA, 1'b0, acc);
        collectResponse("csrrsZero");
        @(negedge clk);
        checkOutput("csrrsZero_store", mem[12'h300], 32'hA);
        checkOutput("csrrsZero_noWrite", 32'(writeCount), 32'(wc));

        // CSRRC clears bit 1
        applyStimulus(CSR_OP_RC, 12'h300, 32'h2, 1'b0, 32'hA, 1'b0, acc);
        collectResponse("csrrc");
        @(negedge clk);
        checkOutput("csrrc_store", mem[12'h300], 32'h8);

        // Write into read-only space is illegal, no write
        pokeStorage(12'hC00, 32'h0000_1234);
        wc = writeCount;
        applyStimulus(CSR_OP_RW, 12'hC00, 32'h55, 1'b0, 32'h0, 1'b1, acc);
        collectResponse("roWrite");
        @(negedge clk);
        checkOutput("roWrite_store", mem[12'hC00], 32'h1234);
        checkOutput("roWrite_noWrite", 32'(writeCount), 32'(wc));

        // Read of read-only space is legal
        applyStimulus(CSR_OP_RS, 12'hC00, 32'h0, 1'b1, 32'h1234, 1'b0, acc);
        collectResponse("roRead");

        // Reserved funct3 is illegal and leaves storage alone
        applyStimulus(3'b000, 12'h300, 32'hFF, 1'b0, 32'h0, 1'b1, acc);
        collectResponse("badOp");
        @(negedge clk);
        checkOutput("badOp_store", mem[12'h300], 32'h8);

        // Immediate set form
        pokeStorage(12'h305, 32'h10);
        applyStimulus(CSR_OP_RSI, 12'h305, 32'h5, 1'b0, 32'h10, 1'b0, acc);
        collectResponse("csrrsi");
        @(negedge clk);
        checkOutput("csrrsi_store", mem[12'h305], 32'h15);

        // Reset while in WRITE abandons the operation
        rc = rspCount;
        wc = writeCount;
        req_op       = CSR_OP_RW;
        req_addr     = 12'h300;
        req_src      = 32'h777;
        req_src_zero = 1'b0;
        req_valid    = 1'b1;
        #1;
        readySeen = 1'b0;
        for (int i = 0; i < 20 && !readySeen; i++) begin
            if (req_ready) readySeen = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        checkOutput("midRst_accept", 32'(readySeen), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 checkOutput("midRst_inWrite", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRst_we", 32'(csr_we), 32'(REG_WE_DISABLE));
        checkOutput("midRst_rspValid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midRst_reqReady", 32'(req_ready), 32'd1);
        checkOutput("midRst_store", mem[12'h300], 32'h8);
        checkOutput("midRst_rspCount", 32'(rspCount), 32'(rc));
        checkOutput("midRst_writeCount", 32'(writeCount), 32'(wc));

        // Trap and request in the same cycle: trap first, request right after
        pokeStorage(12'h340, 32'h77);
        t0         = cycleNum;
        trap_pc    = 32'h8000_0103;
        trap_cause = 32'h2;
        trap_valid = 1'b1;
        fork
            begin
                applyStimulus(CSR_OP_RW, 12'h340, 32'hDEAD, 1'b0, 32'h77, 1'b0, acc);
            end
            begin
                #1 checkOutput("trap_blocksReq", 32'(req_ready), 32'd0);
                ackSeen = 1'b0;
                for (int i = 0; i < 10 && !ackSeen; i++) begin
                    @(negedge clk);
                    if (trap_ack) begin
                        ackSeen = 1'b1;
                        checkOutput("trap_ackCycle", 32'(cycleNum), 32'(t0 + 2));
                        trap_valid = 1'b0;
                    end
                end
                if (!ackSeen) begin
                    checkOutput("trap_ackTimeout", 32'd0, 32'd1);
                    trap_valid = 1'b0;
                end
            end
        join
        checkOutput("trap_reqAccept", 32'(acc), 32'(t0 + 3));
        collectResponse("trapReq");
        @(negedge clk);
        checkOutput("trap_mepc", mem[12'h341], 32'h8000_0100);
        checkOutput("trap_mcause", mem[12'h342], 32'h2);
        checkOutput("trap_reqStore", mem[12'h340], 32'hDEAD);

        repeat (2) @(negedge clk);
        checkOutput("rspCountTotal", 32'(rspCount), 32'(pushCount));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
